race_reaction_timer: RTL and testbench



---
 rtl/race_reaction_timer.sv | 87 ++++++++
 tb/tb_race_reaction_timer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/race_reaction_timer.sv
// race_reaction_timer: measures driver reaction time from GREEN to GO_BTN press in ms,
// flagging false starts and timeouts.
module race_reaction_timer #(
  parameter int TICKS_PER_MS = 50_000,
  parameter int MAX_MS = 9999
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        RED,
  input  logic        YELLOW,
  input  logic        GREEN,
  input  logic        GO_BTN,
  output logic [15:0] REACT_MS,
  output logic        VALID,
  output logic        FALSE_START,
  output logic        TIMEOUT,
  output logic        BUSY
);
  localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;
  state_t state;
  logic [3:0] s1, s2;
  logic btn_d;
  logic press;
  logic [PW-1:0] pre;
  logic [15:0] ms;
  // synced bit order: {GO_BTN, GREEN, YELLOW, RED}
  assign press = s2[3] & ~btn_d;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      btn_d <= 1'b0;
      pre <= '0;
      ms <= '0;
      REACT_MS <= '0;
      VALID <= 1'b0;
      FALSE_START <= 1'b0;
      TIMEOUT <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      s1 <= {GO_BTN, GREEN, YELLOW, RED};
      s2 <= s1;
      btn_d <= s2[3];
      case (state)
        IDLE: if (s2[0]) begin
          state <= ARMED;
          REACT_MS <= '0;
          VALID <= 1'b0;
          FALSE_START <= 1'b0;
          TIMEOUT <= 1'b0;
          BUSY <= 1'b1;
        end
        ARMED: if (press) begin
          state <= DONE;
          FALSE_START <= 1'b1;
          REACT_MS <= '0;
          BUSY <= 1'b0;
        end else if (s2[2]) begin
          state <= TIMING;
          pre <= '0;
          ms <= '0;
        end
        TIMING: if (press) begin
          state <= DONE;
          REACT_MS <= ms;
          VALID <= 1'b1;
          BUSY <= 1'b0;
        end else if (ms == 16'(MAX_MS)) begin
          state <= DONE;
          REACT_MS <= ms;
          TIMEOUT <= 1'b1;
          BUSY <= 1'b0;
        end else if (pre == PW'(TICKS_PER_MS - 1)) begin
          // ms only advances below MAX_MS, so the counter saturates there
          pre <= '0;
          ms <= ms + 16'd1;
        end else begin
          pre <= pre + PW'(1);
        end
        DONE: if (s2[2:0] == 3'b000) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_race_reaction_timer.sv
// tb_race_reaction_timer: directed and randomized runs checked every cycle against
// an elapsed-cycle reference model of the reaction timer.
module tb_race_reaction_timer;
  localparam int T = 4;
  localparam int MX = 20;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic RED = 1'b0, YELLOW = 1'b0, GREEN = 1'b0, GO_BTN = 1'b0;
  logic [15:0] REACT_MS;
  logic VALID, FALSE_START, TIMEOUT, BUSY;
  int tests = 0;
  int fails = 0;
  int mst = 0;
  int el = 0;
  int m_react = 0;
  bit m_valid = 0, m_fs = 0, m_to = 0;
  logic [3:0] hist [3] = '{default: '0};

  race_reaction_timer #(.TICKS_PER_MS(T), .MAX_MS(MX)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RED(RED), .YELLOW(YELLOW), .GREEN(GREEN),
    .GO_BTN(GO_BTN), .REACT_MS(REACT_MS), .VALID(VALID), .FALSE_START(FALSE_START),
    .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // Model: pins are seen two edges late; a press is a 0->1 step of the delayed button.
  // Reaction time is the elapsed cycle count in TIMING divided by ticks per ms.
  task automatic model_edge();
    logic [3:0] sy;
    bit pr;
    sy = hist[1];
    pr = hist[1][3] & ~hist[2][3];
    if (RESET) begin
      mst = 0; el = 0; m_react = 0; m_valid = 0; m_fs = 0; m_to = 0;
      hist = '{default: '0};
      return;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {GO_BTN, GREEN, YELLOW, RED};
    case (mst)
      0: if (sy[0]) begin mst = 1; m_react = 0; m_valid = 0; m_fs = 0; m_to = 0; end
      1: if (pr) begin mst = 3; m_fs = 1; m_react = 0; end
         else if (sy[2]) begin mst = 2; el = 0; end
      2: if (pr) begin mst = 3; m_valid = 1; m_react = (el / T > MX) ? MX : el / T; end
         else if (el / T >= MX) begin mst = 3; m_to = 1; m_react = MX; end
         else el++;
      default: if (sy[2:0] == 3'b000) mst = 0;
    endcase
  endtask

  function automatic logic [19:0] model_vec();
    return {16'(m_react), m_valid, m_fs, m_to, (mst == 1 || mst == 2)};
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    tests++;
    assert ({REACT_MS, VALID, FALSE_START, TIMEOUT, BUSY} === exp) else begin
      fails++;
      $error("FAIL %s: got ms=%0d v/fs/to/busy=%b expected ms=%0d v/fs/to/busy=%b",
             tag, REACT_MS, {VALID, FALSE_START, TIMEOUT, BUSY}, exp[19:4], exp[3:0]);
    end
  endtask

  task automatic cyc(input int n, input string tag = "model");
    repeat (n) begin
      @(posedge CLOCK);
      model_edge();
      #1;
      chk(tag, model_vec());
    end
  endtask

  task automatic set(input logic r, input logic y, input logic g, input logic b);
    RED = r; YELLOW = y; GREEN = g; GO_BTN = b;
  endtask

  initial begin
    int mode;
    RESET = 1'b1;
    cyc(2, "reset");
    chk("reset_state", 20'h0);
    RESET = 1'b0;
    cyc(3, "idle");
    // measured run: press 10 ms after synced green
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 0); cyc(41);
    set(0, 0, 1, 1); cyc(4);
    set(0, 0, 1, 0); cyc(3);
    chk("valid_10ms", {16'd10, 4'b1000});
    set(0, 0, 0, 0); cyc(5);
    chk("idle_hold", {16'd10, 4'b1000});
    set(0, 0, 0, 1); cyc(4);
    set(0, 0, 0, 0); cyc(3);
    chk("idle_press_ignored", {16'd10, 4'b1000});
    // false start during yellow, later green ignored
    set(1, 0, 0, 0); cyc(4);
    chk("armed_clears", {16'd0, 4'b0001});
    set(0, 1, 0, 0); cyc(3);
    set(0, 1, 0, 1); cyc(4);
    chk("false_start", {16'd0, 4'b0100});
    set(0, 0, 1, 0); cyc(10);
    chk("fs_green_ignored", {16'd0, 4'b0100});
    set(0, 0, 0, 0); cyc(5);
    // timeout
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 0); cyc(40);
    chk("timing_busy", {16'd0, 4'b0001});
    cyc(50);
    chk("timeout", {16'd20, 4'b0010});
    set(0, 0, 0, 0); cyc(5);
    // press on the cycle synced green rises
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 1); cyc(4);
    chk("press_with_green", {16'd0, 4'b0100});
    set(0, 0, 0, 0); cyc(5);
    // press on the cycle the ms counter reaches the ceiling
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 0); cyc(81);
    set(0, 0, 1, 1); cyc(3);
    chk("press_at_max", {16'd20, 4'b1000});
    set(0, 0, 0, 0); cyc(5);
    // reset mid-timing at ms=7, then green alone must not arm
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 0); cyc(31);
    RESET = 1'b1; cyc(1, "rst_mid");
    chk("rst_mid_clear", 20'h0);
    RESET = 1'b0; cyc(10);
    chk("no_arm_without_red", 20'h0);
    set(0, 0, 0, 0); cyc(3);
    set(1, 0, 0, 0); cyc(4);
    set(0, 0, 1, 0); cyc(21);
    set(0, 0, 1, 1); cyc(3);
    chk("rerun_5ms", {16'd5, 4'b1000});
    set(0, 0, 0, 0); cyc(5);
    // button held across green, then released and pressed 3 ms in
    set(0, 0, 0, 1); cyc(4);
    set(1, 0, 0, 1); cyc(4);
    set(0, 0, 1, 1); cyc(5);
    chk("held_no_result", {16'd0, 4'b0001});
    set(0, 0, 1, 0); cyc(8);
    set(0, 0, 1, 1); cyc(4);
    chk("held_then_3ms", {16'd3, 4'b1000});
    set(0, 0, 0, 0); cyc(5);
    // randomized runs against the model
    for (int r = 0; r < 60; r++) begin
      set(1, 0, 0, 1'($urandom_range(0, 1))); cyc($urandom_range(3, 6));
      if ($urandom_range(0, 1) == 1) begin set(0, 1, 0, 0); cyc($urandom_range(1, 4)); end
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        set(0, 1, 0, 1); cyc($urandom_range(1, 4));
        set(0, 0, 1, 0); cyc($urandom_range(0, 6));
      end else begin
        set(0, 0, 1, 0); cyc($urandom_range(0, 95));
        if ($urandom_range(0, 7) == 0) begin RESET = 1'b1; cyc(1); RESET = 1'b0; end
        set(0, 0, $urandom_range(0, 1) == 1, 1); cyc($urandom_range(1, 3));
        set(0, 0, 1, 0); cyc(3);
      end
      set(0, 0, 0, 1'($urandom_range(0, 1))); cyc($urandom_range(3, 6));
      set(0, 0, 0, 0); cyc(2);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
